// File: rtl/muldiv_pkg.sv
// muldiv_pkg
// Shared definitions for the multiply/divide sequencer: operation codes,
// HI/LO mux select encodings, the sequencer state type and a small helper
// that classifies divider operations.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_DIVM = 2'b10;

    localparam logic HL_SEL_DIV  = 1'b0;
    localparam logic HL_SEL_MULT = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_RUN,
        ST_WRITE,
        ST_DONE,
        ST_ZERO,
        ST_ERR
    } state_t;

    // True for both divider flavours (A/B and B/MDR).
    function automatic logic isDivOp(input logic [1:0] opCode);
        return (opCode == OP_DIV) || (opCode == OP_DIVM);
    endfunction

endpackage

// File: rtl/muldiv_cycle_counter.sv
// muldiv_cycle_counter
// Loadable down-counter used to time the iterative multiplier/divider.
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-low reset, clears the count
//   load_i     - load load_val_i this cycle (has priority over en_i)
//   en_i       - decrement by one; ignored when the count is already zero
//   load_val_i - value to load
//   zero_o     - count is zero
module muldiv_cycle_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Decrement saturates at zero so the count can never wrap around.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
// Sequences the shared iterative multiplier/divider and the HI/LO register
// pair for MULT, DIV and DIVM: pulses the init strobe, holds the operand
// and HI/LO selects, counts the iteration cycles, then commits to HI/LO or
// raises a divide-by-zero exception.
// Ports:
//   clk, reset (async, active-low)
//   start, op[1:0]      - request strobe and opcode from the control unit
//   divisor_zero        - divider zero-divisor flag, sampled in LAUNCH
//   abort               - exception flush, returns to IDLE
//   mult_init, div_init - one-cycle resource start strobes
//   div_src_sel         - 1 selects DIVM operands
//   hl_sel              - 0 divider, 1 multiplier into HI/LO
//   hl_load             - one-cycle HI/LO write enable
//   busy, done          - status and completion pulse
//   div_zero_exc        - divide-by-zero exception pulse
//   op_err              - illegal opcode pulse
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int MULT_CYCLES = 33,
    parameter int DIV_CYCLES  = 33,
    parameter int CNT_W       = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] op,
    input  logic       divisor_zero,
    input  logic       abort,
    output logic       mult_init,
    output logic       div_init,
    output logic       div_src_sel,
    output logic       hl_sel,
    output logic       hl_load,
    output logic       busy,
    output logic       done,
    output logic       div_zero_exc,
    output logic       op_err
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic             divSrcSel_q, divSrcSel_d;
    logic             hlSel_q, hlSel_d;
    logic             cntLoad;
    logic             cntEn;
    logic [CNT_W-1:0] cntLoadVal;
    logic             cntZero;

    muldiv_cycle_counter #(
        .CNT_W(CNT_W)
    ) uCounter (
        .clk       (clk),
        .reset     (reset),
        .load_i    (cntLoad),
        .en_i      (cntEn),
        .load_val_i(cntLoadVal),
        .zero_o    (cntZero)
    );

    // Next-state and Moore output decode. The selects are registered at the
    // accepting edge so they are already valid in LAUNCH and simply hold
    // their last value once the sequencer is back in IDLE. Abort overrides
    // everything at the end: it flushes to IDLE, clears the counter and masks
    // the commit/status pulses in the same cycle.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        divSrcSel_d  = divSrcSel_q;
        hlSel_d      = hlSel_q;
        cntLoad      = 1'b0;
        cntEn        = 1'b0;
        cntLoadVal   = '0;
        mult_init    = 1'b0;
        div_init     = 1'b0;
        hl_load      = 1'b0;
        done         = 1'b0;
        div_zero_exc = 1'b0;
        op_err       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    if (op == 2'b11) begin
                        state_d = ST_ERR;
                    end else begin
                        op_d        = op;
                        divSrcSel_d = (op == OP_DIVM);
                        hlSel_d     = (op == OP_MULT) ? HL_SEL_MULT : HL_SEL_DIV;
                        state_d     = ST_LAUNCH;
                    end
                end
            end
            ST_LAUNCH: begin
                cntLoad = 1'b1;
                if (isDivOp(op_q)) begin
                    div_init   = 1'b1;
                    cntLoadVal = DIV_LOAD;
                    state_d    = divisor_zero ? ST_ZERO : ST_RUN;
                end else begin
                    mult_init  = 1'b1;
                    cntLoadVal = MULT_LOAD;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                cntEn = !cntZero;
                if (cntZero) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                hl_load = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            ST_ZERO: begin
                div_zero_exc = 1'b1;
                state_d      = ST_IDLE;
            end
            ST_ERR: begin
                op_err  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            cntLoad      = 1'b1;
            cntLoadVal   = '0;
            cntEn        = 1'b0;
            hl_load      = 1'b0;
            done         = 1'b0;
            div_zero_exc = 1'b0;
            op_err       = 1'b0;
            if (state_q != ST_IDLE) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_MULT;
            divSrcSel_q <= 1'b0;
            hlSel_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            divSrcSel_q <= divSrcSel_d;
            hlSel_q     <= hlSel_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign hl_sel      = hlSel_q;
    assign div_src_sel = divSrcSel_q;

endmodule
